// File: rtl/cordic_hyp_sched.sv
// Round-robin scheduler sharing one free-running 16-stage hyperbolic CORDIC among N_REQ requesters.
// Optional build macro CORDIC_SCHED_PRIO0_EN gives requester 0 strict priority over the round-robin set.
module cordic_hyp_sched #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int PIPE_LAT   = 17,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_x,
  input  logic [16*N_REQ-1:0]   req_y,
  input  logic [16*N_REQ-1:0]   req_z,
  output logic [15:0]           cdc_xin,
  output logic [15:0]           cdc_yin,
  output logic [15:0]           cdc_zin,
  input  logic [15:0]           cdc_x0,
  input  logic [15:0]           cdc_y0,
  input  logic [15:0]           cdc_z0,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_x,
  output logic [15:0]           rsp_y,
  output logic [15:0]           rsp_z,
  output logic                  busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     x;
    logic [15:0]     y;
    logic [15:0]     z;
  } rsp_t;

  logic [ID_W-1:0]             rr_last, gnt_id, idx;
  logic                        gnt_any, can_issue, issue, push, pop;
  logic [CW-1:0]               credits, cnt;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [PIPE_LAT:0]           vld_pipe;
  logic [PIPE_LAT:0][ID_W-1:0] id_pipe;
  rsp_t                        fifo_mem [FIFO_DEPTH];
  rsp_t                        head;

  // Rotating search starting just after the last winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
`ifdef CORDIC_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int off = 1; off < N_REQ; off++) begin
        idx = ID_W'(((int'(rr_last) + N_REQ - 2 + off) % (N_REQ - 1)) + 1);
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
`else
    for (int off = 1; off <= N_REQ; off++) begin
      idx = ID_W'((int'(rr_last) + off) % N_REQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
`endif
  end

  // Credits count every operand that will eventually occupy a FIFO slot.
  assign can_issue = credits < CW'(FIFO_DEPTH);
  assign issue     = gnt_any & can_issue;
  assign req_ready = issue ? (N_REQ'(1) << gnt_id) : '0;
  assign push      = vld_pipe[PIPE_LAT];
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = credits != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdc_xin  <= '0;
      cdc_yin  <= '0;
      cdc_zin  <= '0;
      rr_last  <= ID_W'(N_REQ - 1);
      vld_pipe <= '0;
      id_pipe  <= '0;
      credits  <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      cdc_xin  <= issue ? req_x[{gnt_id, 4'b0} +: 16] : 16'h0;
      cdc_yin  <= issue ? req_y[{gnt_id, 4'b0} +: 16] : 16'h0;
      cdc_zin  <= issue ? req_z[{gnt_id, 4'b0} +: 16] : 16'h0;
`ifdef CORDIC_SCHED_PRIO0_EN
      if (issue && gnt_id != '0) rr_last <= gnt_id;
`else
      if (issue) rr_last <= gnt_id;
`endif
      vld_pipe <= {vld_pipe[PIPE_LAT-1:0], issue};
      id_pipe  <= {id_pipe[PIPE_LAT-1:0], gnt_id};
      credits  <= credits + CW'(issue) - CW'(pop);
      cnt      <= cnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{id: id_pipe[PIPE_LAT], x: cdc_x0, y: cdc_y0, z: cdc_z0};
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (cnt < CW'(FIFO_DEPTH));
  end

  assign rsp_valid = cnt != '0;
  assign head      = rsp_valid ? fifo_mem[rd_ptr] : '0;
  assign rsp_id    = head.id;
  assign rsp_x     = head.x;
  assign rsp_y     = head.y;
  assign rsp_z     = head.z;
endmodule
